// File: rtl/decode_stage.sv
// Pipelined MIPS-subset instruction decoder with a valid/ready handshake on both
// sides, a 2-entry skid buffer, flush, and a saturating count of retired decodes.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int ALUOP_W = 3,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instruction,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [4:0]         Rs,
  output logic [4:0]         Rt,
  output logic [4:0]         Rd,
  output logic [DATA_W-1:0]  Imm,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegWr,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemOut,
  output logic               DmWr,
  output logic               Branch,
  output logic               BranchNe,
  output logic               Jump,
  output logic               JumpReg,
  output logic               Link,
  output logic               PCWr,
  output logic               illegal,
  output logic [COUNT_W-1:0] decoded_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [DATA_W-1:0]  imm;
    logic [ALUOP_W-1:0] aluop;
    logic               regwr;
    logic               regdst;
    logic               alusrc;
    logic               memout;
    logic               dmwr;
    logic               branch;
    logic               branch_ne;
    logic               jump;
    logic               jump_reg;
    logic               link;
    logic               pcwr;
    logic               illegal;
  } bundle_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  logic [5:0] opcode;
  logic [5:0] funct;
  bundle_t    dec;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Unsupported encodings leave every control bit at its default of zero, so
  // only the illegal flag and the raw fields travel downstream.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec     = '0;
    dec.pc  = in_pc;
    dec.rs  = instruction[25:21];
    dec.rt  = instruction[20:16];
    dec.rd  = instruction[15:11];
    dec.imm = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin dec.regwr = 1'b1; dec.aluop = ALU_ADD; end
          FN_SUB:  begin dec.regwr = 1'b1; dec.aluop = ALU_SUB; end
          FN_AND:  begin dec.regwr = 1'b1; dec.aluop = ALU_AND; end
          FN_OR:   begin dec.regwr = 1'b1; dec.aluop = ALU_OR;  end
          FN_SLT:  begin dec.regwr = 1'b1; dec.aluop = ALU_SLT; end
          FN_JR:   dec.jump_reg = 1'b1;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.regwr  = 1'b1;
        dec.regdst = 1'b1;
        dec.alusrc = 1'b1;
      end
      OP_LW: begin
        dec.regwr  = 1'b1;
        dec.regdst = 1'b1;
        dec.alusrc = 1'b1;
        dec.memout = 1'b1;
      end
      OP_SW: begin
        dec.dmwr   = 1'b1;
        dec.alusrc = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch_ne = 1'b1;
        dec.aluop     = ALU_SUB;
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump  = 1'b1;
        dec.link  = 1'b1;
        dec.regwr = 1'b1;
        dec.rd    = 5'd31;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.pcwr = dec.branch | dec.branch_ne | dec.jump | dec.jump_reg;
  end

  state_t            state_q, state_d;
  bundle_t           head_q, skid_q;
  logic              in_ready_q, out_valid_q;
  logic [COUNT_W-1:0] count_q;

  logic accept, drain;
  logic head_from_dec, head_from_skid, skid_from_dec;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    head_from_dec  = 1'b0;
    head_from_skid = 1'b0;
    skid_from_dec  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d       = ONE;
            head_from_dec = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_from_dec = 1'b1;
          end else if (accept) begin
            state_d       = TWO;
            skid_from_dec = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are flopped from the next state so neither side sees a
  // combinational path through this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer entries are reset too, because the outputs they drive
      // must read zero out of reset, not merely be qualified by out_valid.
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      if (head_from_dec) begin
        head_q <= dec;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (skid_from_dec) begin
        skid_q <= dec;
      end
      if (drain && (count_q != {COUNT_W{1'b1}})) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign decoded_count = count_q;
  assign out_pc        = head_q.pc;
  assign Rs            = head_q.rs;
  assign Rt            = head_q.rt;
  assign Rd            = head_q.rd;
  assign Imm           = head_q.imm;
  assign ALUOp         = head_q.aluop;
  assign RegWr         = head_q.regwr;
  assign RegDst        = head_q.regdst;
  assign ALUSrc        = head_q.alusrc;
  assign MemOut        = head_q.memout;
  assign DmWr          = head_q.dmwr;
  assign Branch        = head_q.branch;
  assign BranchNe      = head_q.branch_ne;
  assign Jump          = head_q.jump;
  assign JumpReg       = head_q.jump_reg;
  assign Link          = head_q.link;
  assign PCWr          = head_q.pcwr;
  assign illegal       = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles are queued on each input
// transfer and compared on each output transfer, plus directed handshake checks.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  aluop;
    logic        regwr;
    logic        regdst;
    logic        alusrc;
    logic        memout;
    logic        dmwr;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        pcwr;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic [2:0]  aluop;
  logic        regwr, regdst, alusrc, memout, dmwr;
  logic        branch, branch_ne, jump, jump_reg, link, pcwr, illegal;
  logic [15:0] decoded_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_imm;
  logic [2:0]  s_aluop;
  logic        s_regwr, s_regdst, s_alusrc, s_memout, s_dmwr;
  logic        s_branch, s_branch_ne, s_jump, s_jump_reg, s_link, s_pcwr, s_illegal;
  logic [1:0]  s_count;

  int      vectors = 0;
  int      miscompares = 0;
  int      pops = 0;
  bundle_t sb[$];
  bundle_t act;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instruction(instr), .in_pc(in_pc),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .Rs(rs), .Rt(rt), .Rd(rd), .Imm(imm), .ALUOp(aluop),
    .RegWr(regwr), .RegDst(regdst), .ALUSrc(alusrc), .MemOut(memout), .DmWr(dmwr),
    .Branch(branch), .BranchNe(branch_ne), .Jump(jump), .JumpReg(jump_reg),
    .Link(link), .PCWr(pcwr), .illegal(illegal), .decoded_count(decoded_count)
  );

  decode_stage #(.COUNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instruction(instr), .in_pc(in_pc),
    .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
    .Rs(s_rs), .Rt(s_rt), .Rd(s_rd), .Imm(s_imm), .ALUOp(s_aluop),
    .RegWr(s_regwr), .RegDst(s_regdst), .ALUSrc(s_alusrc), .MemOut(s_memout), .DmWr(s_dmwr),
    .Branch(s_branch), .BranchNe(s_branch_ne), .Jump(s_jump), .JumpReg(s_jump_reg),
    .Link(s_link), .PCWr(s_pcwr), .illegal(s_illegal), .decoded_count(s_count)
  );

  always_comb begin
    act           = '0;
    act.pc        = out_pc;
    act.rs        = rs;
    act.rt        = rt;
    act.rd        = rd;
    act.imm       = imm;
    act.aluop     = aluop;
    act.regwr     = regwr;
    act.regdst    = regdst;
    act.alusrc    = alusrc;
    act.memout    = memout;
    act.dmwr      = dmwr;
    act.branch    = branch;
    act.branch_ne = branch_ne;
    act.jump      = jump;
    act.jump_reg  = jump_reg;
    act.link      = link;
    act.pcwr      = pcwr;
    act.illegal   = illegal;
  end

  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    b     = '0;
    b.pc  = pc;
    b.rs  = ins[25:21];
    b.rt  = ins[20:16];
    b.rd  = ins[15:11];
    b.imm = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin b.regwr = 1; b.aluop = 3'd0; end
        6'h22: begin b.regwr = 1; b.aluop = 3'd1; end
        6'h24: begin b.regwr = 1; b.aluop = 3'd2; end
        6'h25: begin b.regwr = 1; b.aluop = 3'd3; end
        6'h2A: begin b.regwr = 1; b.aluop = 3'd4; end
        6'h08: begin b.jump_reg = 1; b.pcwr = 1; end
        default: b.illegal = 1;
      endcase
      6'h08: begin b.regwr = 1; b.regdst = 1; b.alusrc = 1; end
      6'h23: begin b.regwr = 1; b.regdst = 1; b.alusrc = 1; b.memout = 1; end
      6'h2B: begin b.dmwr = 1; b.alusrc = 1; end
      6'h04: begin b.branch = 1; b.aluop = 3'd1; b.pcwr = 1; end
      6'h05: begin b.branch_ne = 1; b.aluop = 3'd1; b.pcwr = 1; end
      6'h02: begin b.jump = 1; b.pcwr = 1; end
      6'h03: begin b.jump = 1; b.link = 1; b.regwr = 1; b.rd = 5'd31; b.pcwr = 1; end
      default: b.illegal = 1;
    endcase
    return b;
  endfunction

  // Called at a negedge with inputs settled: scores the handshakes of the
  // coming rising edge, then advances to the next negedge.
  task automatic tick();
    bundle_t e;
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got pc=%h, expected no output", out_pc);
      end else begin
        e = sb.pop_front();
        pops++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL bundle pc=%h: got %h, expected %h", e.pc, act, e);
        end
      end
    end
    if (flush) sb.delete();
    if (rst_n && in_valid && in_ready && !flush) sb.push_back(model(instr, in_pc));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    int n;
    n        = 0;
    instr    = i;
    in_pc    = p;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout pc=%h: in_ready got 0, expected 1", p);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (out_valid && n < 8) begin
      tick();
      n++;
    end
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: out_valid got %b with %0d pending, expected 0 and 0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_handshake: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    vectors++;
    if (act !== '0 || decoded_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got bundle=%h count=%0d, expected all zero", act, decoded_count);
    end
  endtask

  task automatic test_alu();
    logic [31:0] rtype [5];
    rtype = '{32'h0062_2022, 32'h0085_3024, 32'h00A6_3825, 32'h00C7_402A, 32'h03E0_0008};
    out_ready = 1'b1;
    send(32'h03E0_8820, 32'h0000_0100);
    vectors++;
    if (out_valid !== 1'b1 || rd !== 5'd17 || rs !== 5'd31) begin
      miscompares++;
      $display("FAIL add_latency: got out_valid=%b rs=%0d rd=%0d, expected 1 31 17", out_valid, rs, rd);
    end
    tick();
    vectors++;
    if (decoded_count !== 16'd1) begin
      miscompares++;
      $display("FAIL count_first: got %0d, expected 1", decoded_count);
    end
    for (int k = 0; k < 5; k++) send(rtype[k], 32'h0000_0200 + 32'(4 * k));
    drain();
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    send(32'h2009_FFFC, 32'h0000_0300);
    vectors++;
    if (imm !== 32'hFFFF_FFFC || rt !== 5'd9 || alusrc !== 1'b1 || regdst !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_fields: got imm=%h rt=%0d alusrc=%b regdst=%b, expected fffffffc 9 1 1",
               imm, rt, alusrc, regdst);
    end
    send(32'h8D2A_0004, 32'h0000_0304);
    send(32'hAD2A_0008, 32'h0000_0308);
    send(32'h1109_FFFF, 32'h0000_030C);
    send(32'h1509_0002, 32'h0000_0310);
    drain();
  endtask

  task automatic test_jump();
    out_ready = 1'b1;
    send(32'h0C00_0010, 32'h0000_0400);
    vectors++;
    if (jump !== 1'b1 || link !== 1'b1 || rd !== 5'd31 || pcwr !== 1'b1) begin
      miscompares++;
      $display("FAIL jal_fields: got jump=%b link=%b rd=%0d pcwr=%b, expected 1 1 31 1", jump, link, rd, pcwr);
    end
    send(32'h0800_0020, 32'h0000_0404);
    send(32'hFC00_0000, 32'h0000_0408);
    vectors++;
    if (illegal !== 1'b1 || regwr !== 1'b0 || dmwr !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op: got illegal=%b regwr=%b dmwr=%b, expected 1 0 0", illegal, regwr, dmwr);
    end
    send(32'h0123_483F, 32'h0000_040C);
    drain();
  endtask

  task automatic test_back_to_back();
    pops      = 0;
    out_ready = 1'b0;
    send(32'h0000_0020, 32'h0000_0000);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: in_ready got %b, expected 1", in_ready);
    end
    send(32'h0021_0820, 32'h0000_0004);
    vectors++;
    if (in_ready !== 1'b0 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_full: got in_ready=%b out_pc=%h, expected 0 00000000", in_ready, out_pc);
    end
    tick();
    vectors++;
    if (out_pc !== 32'h0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_hold: got out_pc=%h out_valid=%b, expected 00000000 1", out_pc, out_valid);
    end
    out_ready = 1'b1;
    send(32'h0042_1020, 32'h0000_0008);
    drain();
    vectors++;
    if (pops != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d transfers, expected 3", pops);
    end
  endtask

  task automatic test_flush();
    int c;
    out_ready = 1'b0;
    send(32'h0000_0020, 32'h0000_0500);
    send(32'h0000_0020, 32'h0000_0504);
    instr    = 32'h2042_0001;
    in_pc    = 32'h0000_DEAD;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_two: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_leak: out_valid got %b, expected 0", out_valid);
    end
    out_ready = 1'b0;
    send(32'h0000_0022, 32'h0000_0600);
    c         = int'(decoded_count);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    vectors++;
    if (int'(decoded_count) != c + 1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drain: got count=%0d out_valid=%b, expected %0d 0", decoded_count, out_valid, c + 1);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h0000_0020, 32'h0000_0700);
    send(32'h0000_0020, 32'h0000_0704);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || decoded_count !== 16'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got out_valid=%b count=%0d in_ready=%b, expected 0 0 1",
               out_valid, decoded_count, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(32'h0000_0020, 32'h0000_0800 + 32'(4 * k));
    drain();
    vectors++;
    if (s_count !== 2'd3 || decoded_count !== 16'd5) begin
      miscompares++;
      $display("FAIL saturate: got narrow=%0d wide=%0d, expected 3 5", s_count, decoded_count);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    instr     = '0;
    in_pc     = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_alu();
    test_imm();
    test_jump();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
